// File: rtl/core_dec_pkg.sv
// Shared RV32I decode definitions for the decode/issue stage:
// opcode constants, format enumeration, decoded-instruction record and the decoder.
package core_dec_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        uses_rs1;
        logic        uses_rs2;
        fmt_e        fmt;
        logic        we;
        logic        ld;
        logic        st;
        logic        br;
        logic        jmp;
        logic [3:0]  funct;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        logic use_rd;
        d       = '0;
        use_rd  = 1'b0;
        d.fmt   = FMT_ILL;
        d.funct = {inst[30], inst[14:12]};
        case (inst[6:0])
            OPC_LOAD:   begin d.fmt = FMT_I; d.ld = 1'b1; d.we = 1'b1; d.uses_rs1 = 1'b1; use_rd = 1'b1; end
            OPC_STORE:  begin d.fmt = FMT_S; d.st = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_BRANCH: begin d.fmt = FMT_B; d.br = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_OP:     begin d.fmt = FMT_R; d.we = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; use_rd = 1'b1; end
            OPC_OP_IMM: begin d.fmt = FMT_I; d.we = 1'b1; d.uses_rs1 = 1'b1; use_rd = 1'b1; end
            OPC_LUI,
            OPC_AUIPC:  begin d.fmt = FMT_U; d.we = 1'b1; use_rd = 1'b1; end
            OPC_JAL:    begin d.fmt = FMT_J; d.jmp = 1'b1; d.we = 1'b1; use_rd = 1'b1; end
            OPC_JALR:   begin d.fmt = FMT_I; d.jmp = 1'b1; d.we = 1'b1; d.uses_rs1 = 1'b1; use_rd = 1'b1; end
            default:    d.fmt = FMT_ILL;
        endcase
        case (d.fmt)
            FMT_I:   d.imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   d.imm = {inst[31:12], 12'b0};
            FMT_J:   d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        d.rs1 = d.uses_rs1 ? inst[19:15] : 5'd0;
        d.rs2 = d.uses_rs2 ? inst[24:20] : 5'd0;
        d.rd  = use_rd     ? inst[11:7]  : 5'd0;
        d.we  = d.we && (d.rd != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/core_dec_issue_fifo.sv
// Instruction queue between fetch and decode: circular buffer with occupancy count
// and synchronous clear.
module core_dec_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/core_dec_issue.sv
// Decode/issue stage: queues fetched RV32I words, decodes the queue head and issues
// into a registered output slot, inserting one bubble on a load-use dependency.
module core_dec_issue
    import core_dec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_kill,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_ready,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_imm,
    output logic [2:0]       ex_fmt,
    output logic             ex_we,
    output logic             ex_ld,
    output logic             ex_st,
    output logic             ex_br,
    output logic             ex_jmp,
    output logic [3:0]       ex_funct,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned QW = XLEN + 32;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [QW-1:0] q_rdata;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          rdy_en;
    logic          push;
    logic          hazard;
    logic          issue;
    logic          bubble;
    dec_t          head;

    // if_ready is gated by a flop so it stays low throughout reset and rises one edge later
    assign if_ready = rdy_en && (q_count < CW'(DEPTH));
    assign push     = if_valid && if_ready;
    assign head     = decode(q_rdata[31:0]);
    assign hazard   = !q_empty && ex_valid && ex_ld && (ex_rd != 5'd0) &&
                      ((head.uses_rs1 && head.rs1 == ex_rd) ||
                       (head.uses_rs2 && head.rs2 == ex_rd));
    assign issue    = !q_empty && (!ex_valid || ex_ready) && !hazard;
    assign bubble   = hazard && ex_ready && !dec_kill;

    core_dec_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dec_kill),
        .push  (push),
        .pop   (issue),
        .wdata ({if_pc, if_inst}),
        .rdata (q_rdata),
        .count (q_count),
        .empty (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_imm    <= '0;
            ex_fmt    <= '0;
            ex_we     <= 1'b0;
            ex_ld     <= 1'b0;
            ex_st     <= 1'b0;
            ex_br     <= 1'b0;
            ex_jmp    <= 1'b0;
            ex_funct  <= '0;
            stall_cnt <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (dec_kill) begin
                ex_valid <= 1'b0;
            end else if (issue) begin
                ex_valid <= 1'b1;
                ex_pc    <= q_rdata[QW-1:32];
                ex_rs1   <= head.rs1;
                ex_rs2   <= head.rs2;
                ex_rd    <= head.rd;
                ex_imm   <= XLEN'($signed(head.imm));
                ex_fmt   <= head.fmt;
                ex_we    <= head.we;
                ex_ld    <= head.ld;
                ex_st    <= head.st;
                ex_br    <= head.br;
                ex_jmp   <= head.jmp;
                ex_funct <= head.funct;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
            if (bubble && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_dec_issue.sv
// Directed bench for core_dec_issue: queue fill/drain, load-use bubble, immediates,
// kill, mid-transfer reset and pointer wrap with random ex_ready.
module tb_core_dec_issue;
    logic        clk;
    logic        rst_n;
    logic        dec_kill;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_imm;
    logic [2:0]  ex_fmt;
    logic        ex_we, ex_ld, ex_st, ex_br, ex_jmp;
    logic [3:0]  ex_funct;
    logic [15:0] stall_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    core_dec_issue #(.XLEN(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .dec_kill(dec_kill),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .ex_fmt(ex_fmt), .ex_we(ex_we), .ex_ld(ex_ld), .ex_st(ex_st),
        .ex_br(ex_br), .ex_jmp(ex_jmp), .ex_funct(ex_funct), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] addi(input int unsigned rd, input int unsigned imm);
        return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
    endfunction

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    initial begin
        int p;
        int q;
        rst_n = 1'b0; dec_kill = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_ready = 1'b0;
        #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_ex_pc", ex_pc, 0);
        #11 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", if_ready, 1);

        // fill: five pushes with ex_ready low
        for (int i = 1; i <= 5; i++) begin
            push(addi(i, i), 32'h100 + 32'(4 * i));
            chk("fill_rdy", if_ready, 1);
            tick();
        end
        push(addi(6, 6), 32'h118);
        chk("full_rdy", if_ready, 0);
        chk("full_valid", ex_valid, 1);
        chk("full_rd", ex_rd, 1);
        tick();
        chk("hold_rd", ex_rd, 1);
        chk("hold_imm", ex_imm, 1);
        if_valid = 1'b0;
        ex_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_valid", ex_valid, 1);
            chk("drain_rd", ex_rd, 64'(i));
            chk("drain_pc", ex_pc, 64'(32'h100 + 32'(4 * i)));
            tick();
        end
        chk("drain_empty", ex_valid, 0);

        // kill while full with a simultaneous push
        ex_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(addi(i, i), 32'h100 + 32'(4 * i));
            tick();
        end
        chk("kill_pre_full", if_ready, 0);
        dec_kill = 1'b1;
        push(addi(7, 7), 32'h11C);
        ex_ready = 1'b1;
        tick();
        dec_kill = 1'b0;
        if_valid = 1'b0;
        chk("kill_valid", ex_valid, 0);
        chk("kill_count", dut.u_fifo.count, 0);
        chk("kill_rdy", if_ready, 1);
        tick();
        chk("kill_discard", ex_valid, 0);

        // load-use: LW x5,0(x1); ADD x6,x5,x2
        push(32'h0000A283, 32'h200);
        tick();
        push(32'h00228333, 32'h204);
        tick();
        if_valid = 1'b0;
        chk("lw_valid", ex_valid, 1);
        chk("lw_pc", ex_pc, 32'h200);
        chk("lw_ld", ex_ld, 1);
        chk("lw_rd", ex_rd, 5);
        chk("lw_we", ex_we, 1);
        chk("lw_fmt", ex_fmt, 1);
        tick();
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_stall", stall_cnt, 1);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_pc", ex_pc, 32'h204);
        chk("add_rs1", ex_rs1, 5);
        chk("add_rs2", ex_rs2, 2);
        chk("add_rd", ex_rd, 6);
        chk("add_fmt", ex_fmt, 0);
        tick();

        // load to x0: no bubble
        push(32'h0000A003, 32'h300);
        tick();
        push(32'h00200333, 32'h304);
        tick();
        if_valid = 1'b0;
        chk("lw0_pc", ex_pc, 32'h300);
        chk("lw0_we", ex_we, 0);
        chk("lw0_ld", ex_ld, 1);
        tick();
        chk("add0_valid", ex_valid, 1);
        chk("add0_pc", ex_pc, 32'h304);
        chk("add0_stall", stall_cnt, 1);
        tick();

        // immediates and illegal opcode
        push(32'hFE000EE3, 32'h400);
        tick();
        push(32'h123450B7, 32'h404);
        tick();
        push(32'hFE20AC23, 32'h408);
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        chk("beq_fmt", ex_fmt, 3);
        chk("beq_br", ex_br, 1);
        chk("beq_we", ex_we, 0);
        chk("beq_rd", ex_rd, 0);
        tick();
        push(32'hFFFFFFFF, 32'h40C);
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_fmt", ex_fmt, 4);
        chk("lui_rd", ex_rd, 1);
        chk("lui_we", ex_we, 1);
        chk("lui_rs1", ex_rs1, 0);
        tick();
        if_valid = 1'b0;
        chk("sw_imm", ex_imm, 32'hFFFFFFF8);
        chk("sw_fmt", ex_fmt, 2);
        chk("sw_st", ex_st, 1);
        chk("sw_rs1", ex_rs1, 1);
        chk("sw_rs2", ex_rs2, 2);
        chk("sw_rd", ex_rd, 0);
        tick();
        chk("ill_valid", ex_valid, 1);
        chk("ill_fmt", ex_fmt, 6);
        chk("ill_flags", {ex_we, ex_ld, ex_st, ex_br, ex_jmp}, 0);
        chk("ill_regs", {ex_rs1, ex_rs2, ex_rd}, 0);
        chk("ill_imm", ex_imm, 0);
        chk("ill_funct", ex_funct, 4'hF);
        tick();
        chk("imm_end", ex_valid, 0);

        // asynchronous reset in the middle of a transfer
        ex_ready = 1'b0;
        push(addi(1, 1), 32'h500);
        tick();
        push(addi(2, 2), 32'h504);
        tick();
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", if_ready, 0);
        chk("mid_rst_valid", ex_valid, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_rd", ex_rd, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("mid_rel_rdy", if_ready, 1);
        ex_ready = 1'b1;
        tick();
        chk("mid_discard", ex_valid, 0);

        // wrap: 3*DEPTH+1 instructions with random ex_ready
        p = 0;
        q = 0;
        for (int c = 0; c < 400 && q < 13; c++) begin
            if_valid = (p < 13);
            if_inst  = addi((p % 31) + 1, p);
            if_pc    = 32'h1000 + 32'(4 * p);
            ex_ready = 1'($urandom_range(0, 1));
            if (ex_valid && ex_ready) begin
                chk("wrap_pc", ex_pc, 64'(32'h1000 + 32'(4 * q)));
                chk("wrap_imm", ex_imm, 64'(q));
                q++;
            end
            if (if_valid && if_ready) p++;
            tick();
        end
        if_valid = 1'b0;
        chk("wrap_issued", 64'(q), 13);
        chk("wrap_pushed", 64'(p), 13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
